// File: rtl/aes_pkg.sv
// Shared AES definitions: forward/inverse S-box byte tables and the iterator FSM state type.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox_lane.sv
// One combinational S-box byte lane; the inverse table exists only when SUB_BYTE_ITER_INV_EN is defined.
module aes_sbox_lane
  import aes_pkg::*;
(
  input  logic [7:0] data,
  input  logic       inv,
  output logic [7:0] result
);

`ifdef SUB_BYTE_ITER_INV_EN
  assign result = inv ? SBOX_INV[data] : SBOX_FWD[data];
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign result     = SBOX_FWD[data];
`endif

endmodule

// File: rtl/sub_byte_iter.sv
// Iterative AES SubBytes: LANES S-boxes walk the state one chunk per cycle, LSB chunk first.
// Optional inverse S-box support is compiled in with SUB_BYTE_ITER_INV_EN.
module sub_byte_iter
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int LANES      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_inv,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  localparam int NUM_BYTES  = DATA_WIDTH / 8;
  localparam int NUM_CHUNKS = NUM_BYTES / LANES;
  localparam int CHUNK_W    = LANES * 8;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  generate
    if ((DATA_WIDTH % 8) != 0 || (NUM_BYTES % LANES) != 0) begin : g_bad_params
      $error("sub_byte_iter: DATA_WIDTH must be a multiple of 8 and DATA_WIDTH/8 a multiple of LANES");
    end
  endgenerate

  state_e                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg;
  logic [DATA_WIDTH-1:0] work_reg;
  logic [CHUNK_W-1:0]    lane_in, lane_out;
  logic                  inv_sel;
  logic                  accept;
  logic                  last_chunk;

  // in_ready is gated by rst so nothing is offered while reset is held.
  assign in_ready   = (state_reg == ST_IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign last_chunk = (cnt_reg == LAST_CHUNK);
  assign out_data   = work_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_BUSY;
      ST_BUSY: begin
        busy = 1'b1;
        if (last_chunk) state_next = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Working register doubles as the result; it is overwritten chunk by chunk in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg  <= '0;
      work_reg <= '0;
    end else if (accept) begin
      cnt_reg  <= '0;
      work_reg <= in_data;
    end else if (state_reg == ST_BUSY) begin
      for (int c = 0; c < NUM_CHUNKS; c++) begin
        if (cnt_reg == CNT_W'(c)) work_reg[c*CHUNK_W +: CHUNK_W] <= lane_out;
      end
      if (!last_chunk) cnt_reg <= cnt_reg + 1'b1;
    end
  end

`ifdef SUB_BYTE_ITER_INV_EN
  logic inv_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         inv_reg <= 1'b0;
    else if (accept) inv_reg <= in_inv;
  end
  assign inv_sel = inv_reg;
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign inv_sel       = 1'b0;
`endif

  always_comb begin
    lane_in = '0;
    for (int c = 0; c < NUM_CHUNKS; c++) begin
      if (cnt_reg == CNT_W'(c)) lane_in = work_reg[c*CHUNK_W +: CHUNK_W];
    end
  end

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      aes_sbox_lane u_lane (
        .data   (lane_in[gi*8 +: 8]),
        .inv    (inv_sel),
        .result (lane_out[gi*8 +: 8])
      );
    end
  endgenerate

endmodule

// File: tb/tb_sub_byte_iter.sv
// Self-checking bench for sub_byte_iter: S-box reference derived from GF(2^8) arithmetic.
module tb_sub_byte_iter;

`ifdef SUB_BYTE_ITER_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_inv, out_valid, out_ready, busy;
  logic [127:0] in_data, out_data;
  logic         in_valid16, in_ready16, in_inv16, out_valid16, out_ready16, busy16;
  logic [127:0] in_data16, out_data16;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_fwd [256];
  logic [7:0] ref_inv [256];

  always #5 clk = ~clk;

  sub_byte_iter #(.DATA_WIDTH(128), .LANES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  sub_byte_iter #(.DATA_WIDTH(128), .LANES(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .in_inv(in_inv16),
    .in_data(in_data16), .out_valid(out_valid16), .out_ready(out_ready16), .out_data(out_data16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_ref();
    logic [7:0] g, s;
    for (int x = 0; x < 256; x++) begin
      g = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) g = 8'(y);
      s = g ^ rotl8(g, 1) ^ rotl8(g, 2) ^ rotl8(g, 3) ^ rotl8(g, 4) ^ 8'h63;
      ref_fwd[x] = s;
      ref_inv[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[8*i +: 8] = (inv && INV_EN) ? ref_inv[d[8*i +: 8]] : ref_fwd[d[8*i +: 8]];
    return r;
  endfunction

  // Offer one state, wait for the result, stall `stall` cycles, then consume it.
  task automatic do_txn(input string tag, input logic [127:0] d, input logic inv, input int stall,
                        output logic [127:0] got, output int lat);
    int guard = 0;
    while (!in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    check({tag, "_ready"}, in_ready, 1'b1);
    in_valid = 1'b1; in_data = d; in_inv = inv;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_inv   = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    got = out_data;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check({tag, "_hold_data"}, out_data, got);
      check({tag, "_hold_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_released"}, out_valid, 1'b0);
    $display("txn %s data=%h inv=%0d out=%h lat=%0d", tag, d, inv, got, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] got, a, b, cur;
    logic [127:0] exp_q [$];
    int lat, guard, last_acc, n_acc;
    logic inv;

    rst = 1'b1;
    in_valid = 0; in_inv = 0; in_data = '0; out_ready = 0;
    in_valid16 = 0; in_inv16 = 0; in_data16 = '0; out_ready16 = 0;
    build_ref();

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_in_ready16", in_ready16, 1'b0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);

    // Known forward vector
    do_txn("fwd_vec", 128'h00112233445566778899aabbccddeeff, 1'b0, 0, got, lat);
    check("fwd_vec_lat", lat, 4);
    check("fwd_vec_data", got, 128'h638293c31bfc33f5c4eeacea4bc12816);

    // Known inverse vector; forward images when the inverse lanes are not built
    do_txn("inv_vec", 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 0, got, lat);
    if (INV_EN) check("inv_vec_data", got, 128'h00112233445566778899aabbccddeeff);
    else        check("inv_vec_fwd_data", got, ref_sub(128'h638293c31bfc33f5c4eeacea4bc12816, 1'b0));
    if (!INV_EN) check("inv_vec_byte63", got[127:120], 8'hfb);

    // Backpressure with a second offer ignored while DONE
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; in_data = a; in_inv = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    check("bp_lat", guard, 4);
    got = out_data;
    check("bp_data", got, ref_sub(a, 1'b0));
    in_valid = 1'b1; in_data = b;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk); #1;
      check("bp_hold_data", out_data, got);
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_handover_busy", busy, 1'b0);
    check("bp_handover_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_second_accepted", busy, 1'b1);
    guard = 0;
    while (!out_valid && guard < 50) begin @(posedge clk); #1; guard++; end
    check("bp_second_data", out_data, ref_sub(b, 1'b0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    $display("txn backpressure first=%h second=%h", a, b);

    // Reset during chunk 2
    in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", in_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_release_ready", in_ready, 1'b1);
    do_txn("after_rst", '0, 1'b0, 0, got, lat);
    check("after_rst_data", got, {16{8'h63}});

    // Randomized transactions against the reference model
    for (int t = 0; t < 20; t++) begin
      a   = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      do_txn("rand", a, inv, $urandom_range(0, 3), got, lat);
      check("rand_lat", lat, 4);
      check("rand_data", got, ref_sub(a, inv));
    end

    // Single-cycle configuration
    @(posedge clk); #1;
    in_valid16 = 1'b1; in_data16 = {16{8'h53}};
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    guard = 0;
    while (!out_valid16 && guard < 50) begin @(posedge clk); #1; guard++; end
    check("l16_lat", guard, 1);
    check("l16_data", out_data16, {16{8'hed}});
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    $display("txn lanes16 data=%h", {16{8'h53}});

    // Back-to-back stream: one accept every 3 cycles
    cur = {$urandom, $urandom, $urandom, $urandom};
    in_valid16 = 1'b1; in_data16 = cur; out_ready16 = 1'b1;
    last_acc = -1; n_acc = 0;
    for (int cyc = 0; cyc < 15; cyc++) begin
      logic acc, con;
      acc = in_valid16 && in_ready16;
      con = out_valid16 && out_ready16;
      if (con) begin
        if (exp_q.size() > 0) check("b2b_data", out_data16, exp_q.pop_front());
        else                  check("b2b_unexpected_out", con, 1'b0);
      end
      if (acc) begin
        if (last_acc >= 0) check("b2b_gap", cyc - last_acc, 3);
        last_acc = cyc;
        n_acc++;
        exp_q.push_back(ref_sub(cur, 1'b0));
        $display("txn b2b cyc=%0d data=%h", cyc, cur);
      end
      @(posedge clk); #1;
      if (acc) begin
        cur = {$urandom, $urandom, $urandom, $urandom};
        in_data16 = cur;
      end
    end
    in_valid16 = 1'b0;
    check("b2b_accepts", n_acc, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
